// File: rtl/sixteen_bit_lod_unit_pkg.sv
// Shared log-multiplier constants and the operand/mask word type
// used by the leading-one detector.
package sixteen_bit_lod_unit_pkg;

   localparam int LOD_WIDTH   = 16;
   localparam int NIBBLE_W    = 4;
   localparam int NUM_NIBBLES = LOD_WIDTH / NIBBLE_W;

   typedef logic [LOD_WIDTH-1:0] lod_word_t;

endpackage

// File: rtl/sixteen_bit_lod_unit_if.sv
// Operand/result bundle for the leading-one detector; the master drives d,
// the slave (the detector) returns the one-hot mask and zero flag.
interface sixteen_bit_lod_unit_if;
   import sixteen_bit_lod_unit_pkg::*;

   lod_word_t d;
   lod_word_t o;
   logic      zero_input_flag;

   modport master (output d, input o, input zero_input_flag);
   modport slave  (input d, output o, output zero_input_flag);

endinterface

// File: rtl/sixteen_bit_lod_unit_lod4.sv
// Combinational 4-bit leading-one detector: one-hot mask of the highest set
// bit plus a nonzero indication.
module sixteen_bit_lod_unit_lod4
   import sixteen_bit_lod_unit_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   output logic [NIBBLE_W-1:0] mask,
   output logic                nonzero
);

   // Each bit survives only if every bit above it is clear.
   assign mask[3] = a[3];
   assign mask[2] = a[2] & ~a[3];
   assign mask[1] = a[1] & ~(|a[3:2]);
   assign mask[0] = a[0] & ~(|a[3:1]);
   assign nonzero = |a;

endmodule

// File: rtl/sixteen_bit_lod_unit.sv
// Registered 16-bit leading-one detector built from four nibble LODs and a
// fifth LOD that picks the leading nonzero nibble.
module sixteen_bit_lod_unit
   import sixteen_bit_lod_unit_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   sixteen_bit_lod_unit_if.slave       bus
);

   logic [NIBBLE_W-1:0]    nib_mask [NUM_NIBBLES];
   logic [NUM_NIBBLES-1:0] nib_nz;
   logic [NUM_NIBBLES-1:0] sel_mask;
   logic                   sel_nz;
   lod_word_t              o_next;
   logic                   zero_next;

   for (genvar g = 0; g < NUM_NIBBLES; g++) begin : g_nibble
      sixteen_bit_lod_unit_lod4 u_lod4 (
         .a       (bus.d[g*NIBBLE_W +: NIBBLE_W]),
         .mask    (nib_mask[g]),
         .nonzero (nib_nz[g])
      );
   end

   sixteen_bit_lod_unit_lod4 u_group_sel (
      .a       (nib_nz),
      .mask    (sel_mask),
      .nonzero (sel_nz)
   );

   // Only the leading nibble's mask passes through; the rest are gated to zero.
   always_comb begin
      o_next = '0;
      for (int g = 0; g < NUM_NIBBLES; g++) begin
         o_next[g*NIBBLE_W +: NIBBLE_W] = nib_mask[g] & {NIBBLE_W{sel_mask[g]}};
      end
   end

   assign zero_next = ~sel_nz;

   // Reset values match an all-zero operand so flag == (o == 0) always holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.o               <= '0;
         bus.zero_input_flag <= 1'b1;
      end else begin
         bus.o               <= o_next;
         bus.zero_input_flag <= zero_next;
      end
   end

endmodule

// File: tb/tb_sixteen_bit_lod_unit.sv
// Self-checking bench for the leading-one detector: directed vectors with
// literal expectations plus a per-cycle comparison against a reference model.
module tb_sixteen_bit_lod_unit;
   import sixteen_bit_lod_unit_pkg::*;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   lod_word_t exp_o;
   logic      exp_flag;
   logic      model_valid = 1'b0;

   sixteen_bit_lod_unit_if bus ();

   sixteen_bit_lod_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Highest set bit wins because the scan runs upward and keeps the last hit.
   function automatic lod_word_t ref_lod(input lod_word_t v);
      lod_word_t r;
      r = '0;
      for (int i = 0; i < LOD_WIDTH; i++) begin
         if (v[i]) r = lod_word_t'(1) << i;
      end
      return r;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         exp_o    <= '0;
         exp_flag <= 1'b1;
      end else begin
         exp_o    <= ref_lod(bus.d);
         exp_flag <= (bus.d == '0);
      end
      model_valid <= 1'b1;
   end

   // Every cycle: model agreement and the structural invariants on o.
   always @(negedge clk) begin
      if (model_valid) begin
         checks++;
         if (bus.o !== exp_o) begin
            errors++;
            $display("[TB] FAIL model_o t=%0t got %h expected %h", $time, bus.o, exp_o);
         end
         checks++;
         if (bus.zero_input_flag !== exp_flag) begin
            errors++;
            $display("[TB] FAIL model_flag t=%0t got %b expected %b", $time, bus.zero_input_flag, exp_flag);
         end
         checks++;
         if ($countones(bus.o) > 1) begin
            errors++;
            $display("[TB] FAIL onehot t=%0t got %h expected popcount<=1", $time, bus.o);
         end
         checks++;
         if (bus.zero_input_flag !== (bus.o == '0)) begin
            errors++;
            $display("[TB] FAIL flag_vs_o t=%0t got flag %b o %h expected flag==(o==0)", $time, bus.zero_input_flag, bus.o);
         end
      end
   end

   task automatic applyStimulus(input logic r, input lod_word_t v);
      @(negedge clk);
      rst   = r;
      bus.d = v;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input lod_word_t want_o, input logic want_flag);
      checks++;
      if (bus.o !== want_o || bus.zero_input_flag !== want_flag) begin
         errors++;
         $display("[TB] FAIL %s got o=%h flag=%b expected o=%h flag=%b",
                  name, bus.o, bus.zero_input_flag, want_o, want_flag);
      end
   endtask

   initial begin
      lod_word_t v;
      rst   = 1'b1;
      bus.d = 16'hFFFF;

      applyStimulus(1'b1, 16'hFFFF);
      checkOutput("reset_ffff", 16'h0000, 1'b1);
      applyStimulus(1'b1, 16'hFFFF);
      checkOutput("reset_hold", 16'h0000, 1'b1);
      applyStimulus(1'b0, 16'h0000);
      checkOutput("release_zero", 16'h0000, 1'b1);

      applyStimulus(1'b0, 16'b1001_1000_0000_1100);
      checkOutput("top_bit", 16'b1000_0000_0000_0000, 1'b0);
      applyStimulus(1'b0, 16'b0001_1000_0000_1100);
      checkOutput("nibble3_low", 16'b0001_0000_0000_0000, 1'b0);
      applyStimulus(1'b0, 16'b0000_0100_1000_1100);
      checkOutput("nibble2_b2b", 16'b0000_0100_0000_0000, 1'b0);

      applyStimulus(1'b0, 16'h000C);
      checkOutput("low_000c", 16'h0008, 1'b0);
      applyStimulus(1'b0, 16'h0001);
      checkOutput("low_0001", 16'h0001, 1'b0);
      applyStimulus(1'b0, 16'h0000);
      checkOutput("zero_after", 16'h0000, 1'b1);

      for (int k = 0; k < LOD_WIDTH; k++) begin
         v = lod_word_t'(1) << k;
         applyStimulus(1'b0, v);
         checkOutput($sformatf("walk1_%0d", k), v, 1'b0);
         applyStimulus(1'b0, lod_word_t'((32'd1 << (k + 1)) - 32'd1));
         checkOutput($sformatf("fill_%0d", k), v, 1'b0);
      end

      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = lod_word_t'($urandom_range(0, 15));
            2:       v = lod_word_t'($urandom_range(0, 255));
            default: v = lod_word_t'($urandom);
         endcase
         applyStimulus(1'b0, v);
      end

      applyStimulus(1'b0, 16'h8000);
      checkOutput("stream_pre", 16'h8000, 1'b0);
      applyStimulus(1'b1, 16'h8000);
      checkOutput("midstream_rst", 16'h0000, 1'b1);
      applyStimulus(1'b0, 16'h8000);
      checkOutput("stream_resume", 16'h8000, 1'b0);

      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sixteen_bit_lod_unit.md
# sixteen_bit_lod_unit

Registered 16-bit leading-one detector (LOD) for the log-multiplier datapath. It keeps only the most significant set bit of the input word, clearing every lower bit. It also flags an all-zero input. Its one-hot output feeds the priority encoder and shifter that form the log-domain characteristic and mantissa.

## Interface
- Parameters: none; width fixed at 16.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- d  input  16  operand word; sampled every rising edge.
- o  output  16  registered one-hot (or zero) leading-one mask of d.
- zero_input_flag  output  1  registered; 1 when sampled d == 16'h0000.

## Operation
- Let k be the highest index with d[k] == 1.
  - o[k] = 1.
  - All other o bits = 0.
- If d == 0:
  - o = 16'h0000.
  - zero_input_flag = 1.
- Otherwise zero_input_flag = 0.
- Invariant: o is either zero or exactly one-hot; popcount(o) ≤ 1.
- Invariant: zero_input_flag == (o == 0) at all times, including reset.
- Pure function of d; no history, no accumulation.
- Hierarchical computation:
  - Split d into four nibbles, d[15:12], d[11:8], d[7:4], d[3:0].
  - Each nibble gets a 4-bit LOD producing a 4-bit one-hot mask and a nibble-nonzero bit.
  - A fifth 4-bit LOD over the four nonzero bits selects the leading nibble.
  - o = selected nibble's mask placed at its nibble position; all other nibbles zero.
  - zero_input_flag = NOR of the four nonzero bits.

## Timing
- Latency: exactly 1 cycle. d sampled at edge N appears on o and zero_input_flag after edge N.
- Throughput: one result per cycle; a new d is accepted every cycle.
- No handshake; no valid, ready, or stall.
- Reset values when rst == 1 at a rising edge:
  - o = 16'h0000.
  - zero_input_flag = 1.
- Reset has priority over d.
- Reset asserted mid-stream: the next edge forces reset values and discards the in-flight result.
- First edge after rst deasserts: outputs reflect d sampled at that edge.
- Outputs change only on clock edges and are glitch-free between edges.
- The combinational path from d to the registers is the 4-bit LOD depth plus one 4-bit LOD plus an AND/OR mux level; it must close at the datapath clock.

## Structure
- Shared log-multiplier package holds:
  - LOD_WIDTH = 16.
  - NIBBLE_W = 4.
  - typedef of the 16-bit operand/mask word.
- One natural sub-module, lod4. It is instantiated five times: four nibble units plus one group selector.
  - Input: 4 bits.
  - Output: 4-bit one-hot mask and a nonzero bit.
  - Purely combinational.
- The top level holds the nibble-combine logic and the output registers.

## Test plan
- Reset: hold rst=1 with d=16'hFFFF → o=16'h0000, zero_input_flag=1. Release rst, d=16'h0000 → same values persist.
- d=16'b1001_1000_0000_1100 → one cycle later o=16'b1000_0000_0000_0000, flag=0.
- d=16'b0001_1000_0000_1100 → o=16'b0001_0000_0000_0000.
  - Then d=16'b0000_0100_1000_1100 → o=16'b0000_0100_0000_0000, both flag=0, back-to-back cycles.
- d=16'h000C → o=16'h0008.
  - Then d=16'h0001 → o=16'h0001.
  - Then d=16'h0000 → o=16'h0000, flag=1.
- Walking one and walking fill, k=0..15:
  - d=1<<k → o=1<<k.
  - d=(1<<(k+1))-1 → o=1<<k.
  - Random d with a reference model: check one-cycle latency, popcount(o)≤1, and flag==(o==0).
- Mid-stream reset: d=16'h8000 streaming, assert rst for one cycle → that cycle o=0 and flag=1. Next cycle o=16'h8000 resumes.
